// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and write-priority helper for reg_file_mp
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD    = 2;
  localparam int DEF_NWR    = 2;
  localparam int ZERO_REG   = 0;

  localparam int MAX_NWR    = 2;
  localparam int MAX_ADDR_W = 16;
  localparam int SEL_W      = 1;

  typedef logic [MAX_ADDR_W-1:0] addr_x_t;

  typedef struct packed {
    logic             hit;
    logic [SEL_W-1:0] port;
  } wr_sel_t;

  // Highest-index enabled port targeting addr wins; register 0 never matches.
  function automatic wr_sel_t wr_select(
    input logic [MAX_NWR-1:0]                 we,
    input logic [MAX_NWR-1:0][MAX_ADDR_W-1:0] wa,
    input addr_x_t                            addr
  );
    wr_sel_t sel;
    sel = '0;
    for (int i = 0; i < MAX_NWR; i++) begin
      if (we[i] && (wa[i] == addr) && (addr != addr_x_t'(ZERO_REG))) begin
        sel.hit  = 1'b1;
        sel.port = SEL_W'(i);
      end
    end
    return sel;
  endfunction

  function automatic logic wr_hit(
    input logic [MAX_NWR-1:0]                 we,
    input logic [MAX_NWR-1:0][MAX_ADDR_W-1:0] wa,
    input addr_x_t                            addr
  );
    wr_sel_t sel;
    sel = wr_select(we, wa, addr);
    return sel.hit;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - per-register pending bits and busy lookup
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] wa,
  input  logic [NRD*ADDR_W-1:0] ra,
  input  logic                  rsv,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic [NRD-1:0]        busy
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0]                   r_pending;
  logic [NREGS-1:0]                   w_pending_nxt;
  logic [MAX_NWR-1:0]                 w_we_x;
  logic [MAX_NWR-1:0][MAX_ADDR_W-1:0] w_wa_x;

  always_comb begin
    w_we_x = '0;
    w_wa_x = '0;
    for (int i = 0; i < NWR; i++) begin
      w_we_x[i] = we[i];
      w_wa_x[i] = MAX_ADDR_W'(wa[i*ADDR_W +: ADDR_W]);
    end
  end

  // Reserve is applied after clears so a new producer supersedes a retiring one.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int i = 0; i < NWR; i++) begin
      if (we[i] && (wa[i*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))) begin
        w_pending_nxt[wa[i*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (rsv && (rsv_addr != ADDR_W'(ZERO_REG))) begin
      w_pending_nxt[rsv_addr] = 1'b1;
    end
    w_pending_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_busy
    logic [ADDR_W-1:0] w_ra;
    logic              w_wr_hit;
    logic              w_rsv_hit;

    assign w_ra      = ra[j*ADDR_W +: ADDR_W];
    assign w_wr_hit  = wr_hit(w_we_x, w_wa_x, MAX_ADDR_W'(w_ra));
    assign w_rsv_hit = rsv && (rsv_addr == w_ra);
    assign busy[j]   = r_pending[w_ra] && (w_ra != ADDR_W'(ZERO_REG)) &&
                       !((BYPASS != 0) && w_wr_hit && !w_rsv_hit);
  end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with write bypass and pending scoreboard
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] wa,
  input  logic [NWR*DATA_W-1:0] wd,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        busy,
  input  logic                  rsv,
  input  logic [ADDR_W-1:0]     rsv_addr
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]                  r_file [NREGS];
  logic [ADDR_W-1:0]                  w_wa   [NWR];
  logic [DATA_W-1:0]                  w_wd   [NWR];
  logic [MAX_NWR-1:0]                 w_we_x;
  logic [MAX_NWR-1:0][MAX_ADDR_W-1:0] w_wa_x;

  for (genvar i = 0; i < NWR; i++) begin : g_wr_unpack
    assign w_wa[i] = wa[i*ADDR_W +: ADDR_W];
    assign w_wd[i] = wd[i*DATA_W +: DATA_W];
  end

  always_comb begin
    w_we_x = '0;
    w_wa_x = '0;
    for (int i = 0; i < NWR; i++) begin
      w_we_x[i] = we[i];
      w_wa_x[i] = MAX_ADDR_W'(w_wa[i]);
    end
  end

  // Later ports overwrite earlier ones in loop order, giving higher-index priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) begin
        r_file[k] <= '0;
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && (w_wa[i] != ADDR_W'(ZERO_REG))) begin
          r_file[w_wa[i]] <= w_wd[i];
        end
      end
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_stored;
    wr_sel_t           w_sel;

    assign w_ra     = ra[j*ADDR_W +: ADDR_W];
    assign w_stored = (w_ra == ADDR_W'(ZERO_REG)) ? '0 : r_file[w_ra];
    assign w_sel    = wr_select(w_we_x, w_wa_x, MAX_ADDR_W'(w_ra));
    // Forwarding is suppressed during reset so reads stay zero.
    assign rd[j*DATA_W +: DATA_W] = ((BYPASS != 0) && !reset && w_sel.hit) ?
                                    w_wd[w_sel.port] : w_stored;
  end

  reg_file_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .wa       (wa),
    .ra       (ra),
    .rsv      (rsv),
    .rsv_addr (rsv_addr),
    .busy     (busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - randomized self-checking bench for reg_file_mp (bypass and non-bypass builds)
`timescale 1ns/1ps
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int NREGS = 2 ** AW;

  logic             clk = 1'b0;
  logic             reset;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wa;
  logic [NW*DW-1:0] wd;
  logic [NR*AW-1:0] ra;
  logic             rsv;
  logic [AW-1:0]    rsv_addr;
  logic [NR*DW-1:0] rd_b, rd_n;
  logic [NR-1:0]    busy_b, busy_n;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] m_mem  [NREGS];
  logic          m_pend [NREGS];

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rd(rd_b), .busy(busy_b), .rsv(rsv), .rsv_addr(rsv_addr)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rd(rd_n), .busy(busy_n), .rsv(rsv), .rsv_addr(rsv_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < NREGS; k++) begin
      m_mem[k]  = '0;
      m_pend[k] = 1'b0;
    end
  endfunction

  function automatic void model_clk();
    logic [AW-1:0] a;
    for (int i = 0; i < NW; i++) begin
      a = wa[i*AW +: AW];
      if (we[i] && a != 0) begin
        m_mem[a]  = wd[i*DW +: DW];
        m_pend[a] = 1'b0;
      end
    end
    if (rsv && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int j, input bit byp);
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    a = ra[j*AW +: AW];
    if (reset || a == 0) return '0;
    v = m_mem[a];
    if (byp) begin
      for (int i = 0; i < NW; i++) begin
        if (we[i] && wa[i*AW +: AW] == a) v = wd[i*DW +: DW];
      end
    end
    return v;
  endfunction

  function automatic logic exp_busy(input int j, input bit byp);
    logic [AW-1:0] a;
    logic          hit;
    a = ra[j*AW +: AW];
    if (reset || a == 0) return 1'b0;
    hit = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (we[i] && wa[i*AW +: AW] == a) hit = 1'b1;
    end
    if (byp && hit && !(rsv && rsv_addr == a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic settle();
    #1;
    for (int j = 0; j < NR; j++) begin
      check($sformatf("rd%0d_byp", j),     rd_b[j*DW +: DW],   exp_rd(j, 1'b1));
      check($sformatf("rd%0d_nobyp", j),   rd_n[j*DW +: DW],   exp_rd(j, 1'b0));
      check($sformatf("busy%0d_byp", j),   32'(busy_b[j]),     32'(exp_busy(j, 1'b1)));
      check($sformatf("busy%0d_nobyp", j), 32'(busy_n[j]),     32'(exp_busy(j, 1'b0)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_clk();
    @(negedge clk);
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0; rsv = 1'b0; rsv_addr = '0;
  endtask

  task automatic set_ra(input int j, input logic [AW-1:0] a);
    ra[j*AW +: AW] = a;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p] = 1'b1;
    wa[p*AW +: AW] = a;
    wd[p*DW +: DW] = d;
  endtask

  task automatic reserve(input logic [AW-1:0] a);
    rsv = 1'b1;
    rsv_addr = a;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, NREGS - 1));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    ra = '0;
    model_clear();
    @(negedge clk);
    settle();
    tick();
    reset = 1'b0;

    for (int r = 0; r < NREGS; r += 2) begin
      idle();
      wr(0, AW'(r), 32'hFFFF_FFFF);
      wr(1, AW'(r + 1), 32'hFFFF_FFFF);
      set_ra(0, AW'(r));
      set_ra(1, AW'(r + 1));
      settle();
      tick();
    end

    idle();
    set_ra(0, 5);
    set_ra(1, 6);
    settle();
    check("pre_reset_r5", rd_b[31:0], 32'hFFFF_FFFF);
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    check("async_rst_rd0_b", rd_b[31:0], 32'h0);
    check("async_rst_rd1_n", rd_n[63:32], 32'h0);
    settle();
    tick();

    for (int r = 0; r < NREGS; r += 2) begin
      idle();
      wr(0, AW'(r), $urandom());
      reserve(AW'(r + 1));
      set_ra(0, AW'(r));
      set_ra(1, AW'(r + 1));
      settle();
      tick();
    end
    reset = 1'b0;
    idle();
    settle();
    tick();

    idle();
    wr(0, 5, 32'h11);
    wr(1, 5, 32'h22);
    set_ra(0, 5);
    set_ra(1, 0);
    settle();
    check("conflict_byp_same", rd_b[31:0], 32'h22);
    check("conflict_nobyp_old", rd_n[31:0], 32'h0);
    tick();
    idle();
    settle();
    check("conflict_next_b", rd_b[31:0], 32'h22);
    check("conflict_next_n", rd_n[31:0], 32'h22);
    tick();

    idle();
    wr(0, 7, 32'h1234);
    settle();
    tick();
    idle();
    wr(0, 7, 32'hABCD);
    set_ra(0, 7);
    settle();
    check("bypass_same_cycle", rd_b[31:0], 32'hABCD);
    check("nobypass_old", rd_n[31:0], 32'h1234);
    tick();
    idle();
    settle();
    check("nobypass_next", rd_n[31:0], 32'hABCD);
    tick();

    idle();
    reserve(3);
    set_ra(0, 3);
    settle();
    check("rsv_busy_not_yet", 32'(busy_b[0]), 32'h0);
    tick();
    idle();
    settle();
    check("rsv_busy_b", 32'(busy_b[0]), 32'h1);
    check("rsv_busy_n", 32'(busy_n[0]), 32'h1);
    tick();
    idle();
    wr(0, 3, 32'h9);
    settle();
    check("wr_clear_busy_b", 32'(busy_b[0]), 32'h0);
    check("wr_clear_busy_n_still", 32'(busy_n[0]), 32'h1);
    check("wr_r3_byp", rd_b[31:0], 32'h9);
    tick();
    idle();
    settle();
    check("wr_clear_busy_n", 32'(busy_n[0]), 32'h0);
    check("wr_r3_nobyp", rd_n[31:0], 32'h9);
    tick();

    idle();
    reserve(4);
    wr(1, 4, 32'h44);
    set_ra(0, 4);
    settle();
    tick();
    idle();
    settle();
    check("rsv_wr_same_b", 32'(busy_b[0]), 32'h1);
    check("rsv_wr_same_n", 32'(busy_n[0]), 32'h1);
    check("rsv_wr_data", rd_n[31:0], 32'h44);
    tick();

    idle();
    reserve(3);
    set_ra(1, 3);
    settle();
    tick();
    idle();
    settle();
    check("pend_r3_r4", 32'(busy_b), 32'h3);
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    check("async_rst_busy_b", 32'(busy_b), 32'h0);
    check("async_rst_busy_n", 32'(busy_n), 32'h0);
    settle();
    tick();
    reset = 1'b0;
    idle();
    settle();
    check("post_rst_pend_b", 32'(busy_b), 32'h0);
    check("post_rst_pend_n", 32'(busy_n), 32'h0);
    tick();

    idle();
    wr(0, 0, 32'h55);
    reserve(0);
    set_ra(0, 0);
    set_ra(1, 0);
    settle();
    check("r0_rd_byp", rd_b[31:0], 32'h0);
    check("r0_busy_byp", 32'(busy_b), 32'h0);
    tick();
    idle();
    settle();
    check("r0_rd_next", rd_n[31:0], 32'h0);
    check("r0_busy_next", 32'(busy_n), 32'h0);
    tick();

    for (int c = 0; c < 600; c++) begin
      idle();
      if (reset && $urandom_range(0, 1) == 1) reset = 1'b0;
      for (int i = 0; i < NW; i++) begin
        we[i] = ($urandom_range(0, 2) != 0);
        wa[i*AW +: AW] = pick_addr();
        wd[i*DW +: DW] = $urandom();
      end
      rsv = ($urandom_range(0, 2) == 0);
      rsv_addr = pick_addr();
      for (int j = 0; j < NR; j++) set_ra(j, pick_addr());
      if (!reset && $urandom_range(0, 49) == 0) begin
        #2;
        reset = 1'b1;
        model_clear();
      end
      settle();
      tick();
    end

    idle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
